// File: rtl/store_dispatch.sv
// store_dispatch: routes one store request from the MEM stage to one of four write
// targets (0 RAM, 1 LED, 2 seven-segment, 3 UART TX), decoded from req_addr[31:28].
// The outputs toward the targets are registered. Each target has its own ready
// handshake. A watchdog aborts a store that its target never accepts, and a
// saturating counter records unmapped and timed-out stores.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   req_valid/ready  store handshake with the MEM stage
//   req_addr/data/be store address, data and byte enables
//   tgt_valid        registered request valid toward the targets
//   tgt_sel          one-hot target strobe, zero when tgt_valid=0
//   tgt_addr/data/be latched store fields, shared by all targets
//   tgt_ready        per-target accept; only the selected bit is used
//   err_pulse        one-cycle pulse on an unmapped address or a timeout
//   err_count        saturating error count
module store_dispatch #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_be,
  output logic        tgt_valid,
  output logic [3:0]  tgt_sel,
  output logic [31:0] tgt_addr,
  output logic [31:0] tgt_data,
  output logic [3:0]  tgt_be,
  input  logic [3:0]  tgt_ready,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic       mapped;
  logic [3:0] req_onehot;
  logic       tgt_hit;

  assign mapped     = (req_addr[31:28] < 4'd4);
  assign req_onehot = 4'b0001 << req_addr[29:28];
  // sel_q is one-hot, so this picks out the ready bit of the selected target only
  assign tgt_hit    = |(sel_q & tgt_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      sel_q   <= 4'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      be_q    <= 4'd0;
      wdog_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    wdog_d  = wdog_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (mapped) begin
            state_d = StSend;
            valid_d = 1'b1;
            sel_d   = req_onehot;
            addr_d  = req_addr;
            data_d  = req_data;
            be_d    = req_be;
            wdog_d  = 8'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (tgt_hit) begin
          if (req_valid && mapped) begin
            // Back-to-back: reload in the completing edge, no bubble
            sel_d  = req_onehot;
            addr_d = req_addr;
            data_d = req_data;
            be_d   = req_be;
            wdog_d = 8'd0;
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            sel_d   = 4'd0;
            err_d   = req_valid;
          end
        end else if (wdog_q == 8'(TIMEOUT - 1)) begin
          // This edge would bring the watchdog to TIMEOUT: abort the store
          state_d = StIdle;
          valid_d = 1'b0;
          sel_d   = 4'd0;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        sel_d   = 4'd0;
      end
    endcase

    cnt_d = (err_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == StIdle) ? 1'b1 : tgt_hit;
    tgt_valid = valid_q;
    tgt_sel   = sel_q;
    tgt_addr  = addr_q;
    tgt_data  = data_q;
    tgt_be    = be_q;
    err_pulse = err_q;
    err_count = cnt_q;
  end

endmodule

// File: tb/tb_store_dispatch.sv
module tb_store_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_be = '0;
  logic [3:0]  tgt_ready = '0;

  logic        req_ready, tgt_valid, err_pulse;
  logic [3:0]  tgt_sel, tgt_be;
  logic [31:0] tgt_addr, tgt_data;
  logic [7:0]  err_count;

  logic        req_ready4, tgt_valid4, err_pulse4;
  logic [3:0]  tgt_sel4, tgt_be4;
  logic [31:0] tgt_addr4, tgt_data4;
  logic [7:0]  err_count4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  store_dispatch dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .tgt_valid(tgt_valid), .tgt_sel(tgt_sel), .tgt_addr(tgt_addr), .tgt_data(tgt_data),
    .tgt_be(tgt_be), .tgt_ready(tgt_ready), .err_pulse(err_pulse), .err_count(err_count)
  );

  store_dispatch #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .tgt_valid(tgt_valid4), .tgt_sel(tgt_sel4), .tgt_addr(tgt_addr4), .tgt_data(tgt_data4),
    .tgt_be(tgt_be4), .tgt_ready(tgt_ready), .err_pulse(err_pulse4), .err_count(err_count4)
  );

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [3:0]  tr;
    logic        e_rdy;
    logic        e_valid;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic        e_ep;
    logic [7:0]  e_ec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic rv, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [3:0] tr, input logic e_rdy,
                      input logic e_valid, input logic [3:0] e_sel, input logic [31:0] e_a,
                      input logic [31:0] e_d, input logic [3:0] e_be, input logic e_ep,
                      input logic [7:0] e_ec);
    vec_t v;
    v.rv = rv; v.addr = a; v.data = d; v.be = be; v.tr = tr;
    v.e_rdy = e_rdy; v.e_valid = e_valid; v.e_sel = e_sel; v.e_addr = e_a;
    v.e_data = e_d; v.e_be = e_be; v.e_ep = e_ep; v.e_ec = e_ec;
    vecs.push_back(v);
  endtask

  // Inputs are driven 1 time unit after the rising edge
  task automatic drive(input logic rv, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [3:0] tr);
    req_valid = rv; req_addr = a; req_data = d; req_be = be; tgt_ready = tr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    //    rv  addr          data          be    tr      rdy v  sel     addr          data          be    ep ec
    addv(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 4'b0010, 1, 1, 4'b0010, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
    addv(0, 32'h0,         32'h0,         4'h0, 4'b0010, 1, 0, 4'b0000, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
    addv(1, 32'h0000_0000, 32'h1111_1111, 4'hF, 4'b0001, 1, 1, 4'b0001, 32'h0000_0000, 32'h1111_1111, 4'hF, 0, 0);
    addv(1, 32'h0000_0004, 32'h2222_2222, 4'h3, 4'b0001, 1, 1, 4'b0001, 32'h0000_0004, 32'h2222_2222, 4'h3, 0, 0);
    addv(1, 32'h0000_0008, 32'h3333_3333, 4'hC, 4'b0001, 1, 1, 4'b0001, 32'h0000_0008, 32'h3333_3333, 4'hC, 0, 0);
    addv(1, 32'h0000_000C, 32'h4444_4444, 4'h1, 4'b0001, 1, 1, 4'b0001, 32'h0000_000C, 32'h4444_4444, 4'h1, 0, 0);
    addv(0, 32'h0,         32'h0,         4'h0, 4'b0001, 1, 0, 4'b0000, 32'h0000_000C, 32'h4444_4444, 4'h1, 0, 0);
    addv(1, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 4'b0001, 1, 1, 4'b1000, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 0, 0);
    for (int i = 0; i < 5; i++)
      addv(1, 32'h0000_0010, 32'h5555_5555, 4'h2, 4'b0001, 0, 1, 4'b1000, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 0, 0);
    addv(0, 32'h0,         32'h0,         4'h0, 4'b1001, 1, 0, 4'b0000, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 0, 0);
    addv(1, 32'h7000_0000, 32'h7777_7777, 4'hF, 4'b0000, 1, 0, 4'b0000, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 1, 1);
    addv(0, 32'h0,         32'h0,         4'h0, 4'b0000, 1, 0, 4'b0000, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 0, 1);
    addv(1, 32'h2000_0008, 32'h2222_0000, 4'h6, 4'b0100, 1, 1, 4'b0100, 32'h2000_0008, 32'h2222_0000, 4'h6, 0, 1);
    addv(1, 32'h8000_0000, 32'h8888_8888, 4'hF, 4'b0100, 1, 0, 4'b0000, 32'h2000_0008, 32'h2222_0000, 4'h6, 1, 2);
    addv(0, 32'h0,         32'h0,         4'h0, 4'b0000, 1, 0, 4'b0000, 32'h2000_0008, 32'h2222_0000, 4'h6, 0, 2);

    // Reset values
    do_reset();
    #3;
    chk("reset tgt_valid", 32'(tgt_valid), 32'h0);
    chk("reset tgt_sel", 32'(tgt_sel), 32'h0);
    chk("reset tgt_data", tgt_data, 32'h0);
    chk("reset err_count", 32'(err_count), 32'h0);
    chk("reset req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      drive(vecs[i].rv, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].tr);
      #4;
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d tgt_valid", i), 32'(tgt_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d tgt_sel", i), 32'(tgt_sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d tgt_addr", i), tgt_addr, vecs[i].e_addr);
      chk($sformatf("v%0d tgt_data", i), tgt_data, vecs[i].e_data);
      chk($sformatf("v%0d tgt_be", i), 32'(tgt_be), 32'(vecs[i].e_be));
      chk($sformatf("v%0d err_pulse", i), 32'(err_pulse), 32'(vecs[i].e_ep));
      chk($sformatf("v%0d err_count", i), 32'(err_count), 32'(vecs[i].e_ec));
    end

    // Timeout with TIMEOUT=4, target ready stuck low
    do_reset();
    @(posedge clk);
    #1;
    drive(1'b1, 32'h2000_0000, 32'hCAFE_0000, 4'hF, 4'b0000);
    #4 chk("to accept ready", 32'(req_ready4), 32'h1);
    @(posedge clk);
    #1;
    chk("to enter valid", 32'(tgt_valid4), 32'h1);
    chk("to enter sel", 32'(tgt_sel4), 32'h4);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);
    for (int k = 1; k <= 3; k++) begin
      #4 chk($sformatf("to hold%0d ready", k), 32'(req_ready4), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("to hold%0d valid", k), 32'(tgt_valid4), 32'h1);
      chk($sformatf("to hold%0d err_pulse", k), 32'(err_pulse4), 32'h0);
    end
    #4 chk("to abort ready", 32'(req_ready4), 32'h0);
    @(posedge clk);
    #1;
    chk("to abort valid", 32'(tgt_valid4), 32'h0);
    chk("to abort sel", 32'(tgt_sel4), 32'h0);
    chk("to abort err_pulse", 32'(err_pulse4), 32'h1);
    chk("to abort err_count", 32'(err_count4), 32'h1);
    @(posedge clk);
    #1;
    chk("to pulse end", 32'(err_pulse4), 32'h0);

    // Saturation: 300 unmapped stores on top of the single timeout
    drive(1'b1, 32'hF000_0000, 32'h0, 4'hF, 4'b0000);
    #4 chk("sat ready", 32'(req_ready4), 32'h1);
    repeat (300) @(posedge clk);
    #1;
    chk("sat err_count", 32'(err_count4), 32'hFF);
    chk("sat err_pulse", 32'(err_pulse4), 32'h1);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);

    // Reset in the middle of SEND
    do_reset();
    @(posedge clk);
    #1;
    drive(1'b1, 32'h1000_0000, 32'h9999_9999, 4'hF, 4'b0000);
    @(posedge clk);
    #1;
    chk("mid send valid", 32'(tgt_valid), 32'h1);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);
    #1 rst = 1'b1;
    #1;
    chk("async rst valid", 32'(tgt_valid), 32'h0);
    chk("async rst sel", 32'(tgt_sel), 32'h0);
    chk("async rst data", tgt_data, 32'h0);
    chk("async rst addr", tgt_addr, 32'h0);
    chk("async rst err_count", 32'(err_count), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 32'h0000_0020, 32'h0000_1234, 4'h3, 4'b0001);
    #4 chk("post rst ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("post rst valid", 32'(tgt_valid), 32'h1);
    chk("post rst sel", 32'(tgt_sel), 32'h1);
    chk("post rst data", tgt_data, 32'h0000_1234);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 4'b0001);
    @(posedge clk);
    #1;
    chk("post rst done", 32'(tgt_valid), 32'h0);
    chk("post rst err_count", 32'(err_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
